// File: rtl/wav_play_ctrl.sv
// WAV playback sequencer: fetches source words into the header parser, buffers the
// parser's samples in a FIFO and releases them at the sample rate from a phase accumulator.
module wav_play_ctrl #(
    parameter int SYS_CLK    = 50_000_000,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [15:0]       rd_data,
    output logic              par_rstn,
    output logic              par_en,
    output logic [15:0]       par_data,
    input  logic              par_outen,
    input  logic [15:0]       par_out,
    input  logic              par_error,
    input  logic [31:0]       par_sample_rate,
    input  logic [31:0]       par_data_size,
    output logic              smp_tick,
    output logic [15:0]       smp_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       underruns
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [33:0]   sum_t;
    localparam sum_t SYS_W    = sum_t'(SYS_CLK);
    localparam cnt_t CNT_LIM  = cnt_t'(FIFO_DEPTH - 2);
    localparam cnt_t CNT_FULL = cnt_t'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRST   = 3'd1;
    localparam logic [2:0] S_HEADER = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              outst_q, outst_d, rd_req_q, rd_req_d;
    logic              par_en_q, par_en_d, cap_q, cap_d;
    logic [15:0]       par_data_q, par_data_d;
    ptr_t              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t              cnt_q, cnt_d;
    logic [31:0]       words_left_q, words_left_d;
    logic [32:0]       acc_q, acc_d;
    logic              smp_tick_q, smp_tick_d;
    logic [15:0]       smp_data_q, smp_data_d, underruns_q, underruns_d;
    logic              err_q, err_d, done_q, done_d;
    logic [15:0]       mem [FIFO_DEPTH];

    logic rd_ok, err_hit, accept, push, pop, pacing, tick, start_go, rate_bad;
    sum_t sum;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        outst_d      = outst_q;
        rd_req_d     = 1'b0;
        par_en_d     = 1'b0;
        par_data_d   = par_data_q;
        cap_d        = par_en_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        words_left_d = words_left_q;
        acc_d        = acc_q;
        smp_tick_d   = 1'b0;
        smp_data_d   = smp_data_q;
        underruns_d  = underruns_q;
        err_d        = err_q;
        done_d       = 1'b0;

        start_go = start && !stop;
        rd_ok    = rd_valid && outst_q;
        rate_bad = (par_sample_rate == 32'd0) || (par_sample_rate > 32'(SYS_CLK));
        // The parser reset cycle can still show a stale error, so only live states count it.
        err_hit  = par_error && (state_q == S_HEADER || state_q == S_STREAM || state_q == S_DRAIN);
        accept   = (state_q == S_HEADER) || (state_q == S_STREAM && words_left_q != '0);
        push     = cap_q && par_outen && accept && (cnt_q != CNT_FULL);
        pacing   = (state_q == S_STREAM || state_q == S_DRAIN) && !stop && !err_hit;
        sum      = sum_t'(acc_q) + sum_t'(par_sample_rate);
        tick     = pacing && (sum >= SYS_W);
        pop      = tick && (cnt_q != '0);

        if (rd_ok) begin
            par_en_d   = 1'b1;
            par_data_d = rd_data;
            addr_d     = addr_q + ADDR_W'(1);
            outst_d    = 1'b0;
        end
        // Two free slots: one for a word still in the parser pipe, one for this read.
        if (accept && !outst_q && cnt_q <= CNT_LIM && !err_hit && !stop) begin
            rd_req_d = 1'b1;
            outst_d  = 1'b1;
        end

        if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
        cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);

        if (pacing) acc_d = tick ? 33'(sum - SYS_W) : sum[32:0];
        if (tick) begin
            smp_tick_d = 1'b1;
            smp_data_d = pop ? mem[rd_ptr_q] : 16'h0000;
            if (!pop && underruns_q != 16'hFFFF) underruns_d = underruns_q + 16'd1;
        end

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start_go) begin
                    state_d      = S_PRST;
                    addr_d       = '0;
                    outst_d      = 1'b0;
                    par_en_d     = 1'b0;
                    cap_d        = 1'b0;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    cnt_d        = '0;
                    words_left_d = '0;
                    acc_d        = '0;
                    underruns_d  = '0;
                    err_d        = 1'b0;
                end
            end
            S_PRST: state_d = S_HEADER;
            S_HEADER: begin
                if (push) begin
                    words_left_d = (par_data_size >> 1) - 32'd1;
                    if ((par_data_size >> 1) == 32'd0) words_left_d = '0;
                    state_d = rate_bad ? S_ERR : S_STREAM;
                    err_d   = err_q | rate_bad;
                end
            end
            S_STREAM: begin
                if (push) words_left_d = words_left_q - 32'd1;
                if (words_left_q == '0) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_q == '0 && !tick) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (err_hit) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            done_d  = 1'b0;
        end
        if (stop) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            outst_d  = 1'b0;
            par_en_d = 1'b0;
            cap_d    = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= par_out;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            outst_q      <= 1'b0;
            rd_req_q     <= 1'b0;
            par_en_q     <= 1'b0;
            par_data_q   <= '0;
            cap_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            words_left_q <= '0;
            acc_q        <= '0;
            smp_tick_q   <= 1'b0;
            smp_data_q   <= '0;
            underruns_q  <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            outst_q      <= outst_d;
            rd_req_q     <= rd_req_d;
            par_en_q     <= par_en_d;
            par_data_q   <= par_data_d;
            cap_q        <= cap_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            words_left_q <= words_left_d;
            acc_q        <= acc_d;
            smp_tick_q   <= smp_tick_d;
            smp_data_q   <= smp_data_d;
            underruns_q  <= underruns_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    assign rd_req    = rd_req_q;
    assign rd_addr   = addr_q;
    assign par_rstn  = (state_q != S_PRST);
    assign par_en    = par_en_q;
    assign par_data  = par_data_q;
    assign smp_tick  = smp_tick_q;
    assign smp_data  = smp_data_q;
    assign busy      = (state_q == S_HEADER) || (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign done      = done_q;
    assign err       = err_q;
    assign underruns = underruns_q;
endmodule

// File: tb/tb_wav_play_ctrl.sv
// Bench for wav_play_ctrl: behavioural source and parser, scoreboard of sample words
// queued as the source serves them and popped as smp_tick releases them.
module tb_wav_play_ctrl;
    localparam int SYS = 8000;
    localparam int HDR = 22;

    logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, stop = 1'b0;
    logic        rd_req, rd_valid, par_rstn, par_en, par_outen, par_error;
    logic [23:0] rd_addr;
    logic [15:0] rd_data, par_data, par_out, smp_data, underruns;
    logic [31:0] par_sample_rate = 32'd800, par_data_size = 32'd8;
    logic        smp_tick, busy, done, err;

    int n_tests = 0, n_fail = 0;
    int src_delay = 0, data_words = 4;
    logic [15:0] hdr0 = 16'h4952;
    logic [15:0] exp_q[$];
    longint tick_t[$];
    longint cyc = 0;
    int tick_cnt, done_cnt, pe_cnt, req_cnt, zero_cnt, prst_cnt, rv_cnt;

    always #5 clk = ~clk;

    wav_play_ctrl #(.SYS_CLK(SYS), .FIFO_DEPTH(16), .ADDR_W(24)) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .par_rstn(par_rstn), .par_en(par_en), .par_data(par_data),
        .par_outen(par_outen), .par_out(par_out), .par_error(par_error),
        .par_sample_rate(par_sample_rate), .par_data_size(par_data_size),
        .smp_tick(smp_tick), .smp_data(smp_data), .busy(busy), .done(done),
        .err(err), .underruns(underruns)
    );

    function automatic logic [15:0] src_word(input logic [23:0] a);
        if (a == 24'd0) return hdr0;
        if (a < 24'(HDR)) return 16'h1000 + 16'(a);
        return 16'hA000 + a[15:0];
    endfunction

    // Word source: answers one request after src_delay extra cycles.
    initial begin
        bit pend;
        int wt;
        logic [23:0] a;
        pend = 0; wt = 0; a = '0;
        rd_valid = 1'b0; rd_data = '0;
        forever begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (pend) begin
                if (wt == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = src_word(a);
                    pend     = 0;
                    if (a >= 24'(HDR) && a < 24'(HDR + data_words)) exp_q.push_back(rd_data);
                end else wt--;
            end
            if (rd_req) begin pend = 1; wt = src_delay; a = rd_addr; end
        end
    end

    // Parser stand-in: 22 header words, then every absorbed word is a sample.
    initial begin
        int idx;
        idx = 0;
        par_outen = 1'b0; par_out = '0; par_error = 1'b0;
        forever begin
            @(negedge clk);
            if (!par_rstn) begin
                idx = 0; par_outen = 1'b0; par_error = 1'b0; par_out = '0;
            end else if (par_en) begin
                if (idx == 0 && par_data !== 16'h4952) par_error = 1'b1;
                par_outen = (idx >= HDR);
                if (idx >= HDR) par_out = par_data;
                idx++;
            end
        end
    end

    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (par_en)    pe_cnt++;
            if (rd_req)    req_cnt++;
            if (rd_valid)  rv_cnt++;
            if (done)      done_cnt++;
            if (!par_rstn) prst_cnt++;
            if (smp_tick) begin
                tick_cnt++;
                tick_t.push_back(cyc);
                if (smp_data == 16'h0000) zero_cnt++;
                else begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sample_order: got %h, required nothing (no word queued)", smp_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (smp_data !== e) begin
                            n_fail++;
                            $display("FAIL sample_order: got %h, required %h", smp_data, e);
                        end
                    end
                end
            end
        end
    end

    task automatic clr();
        tick_cnt = 0; done_cnt = 0; pe_cnt = 0; req_cnt = 0; zero_cnt = 0;
        prst_cnt = 0; rv_cnt = 0;
        tick_t.delete();
        exp_q.delete();
    endtask

    task automatic pulse(input bit s, input bit p);
        @(posedge clk); #1;
        start = s; stop = p;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_done(input int lim, input string nm);
        int k;
        k = 0;
        while (done_cnt == 0 && k < lim) begin @(negedge clk); k++; end
        n_tests++;
        if (done_cnt == 0) begin n_fail++; $display("FAIL %s_done: no done within %0d cycles", nm, lim); end
    endtask

    task automatic wait_tick(input int lim, input string nm);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!smp_tick && k < lim);
        n_tests++;
        if (!smp_tick) begin n_fail++; $display("FAIL %s_tick: no smp_tick within %0d cycles", nm, lim); end
    endtask

    task automatic setup(input logic [31:0] rate, input logic [31:0] size, input int dly);
        @(posedge clk); #1;
        par_sample_rate = rate; par_data_size = size; data_words = int'(size >> 1);
        src_delay = dly; hdr0 = 16'h4952;
        clr();
    endtask

    task automatic test_reset();
        #22;
        n_tests++;
        if ({rd_req, par_en, smp_tick, busy, done, err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b, required 000000", {rd_req, par_en, smp_tick, busy, done, err});
        end
        n_tests++;
        if (par_rstn !== 1'b1) begin n_fail++; $display("FAIL reset_par_rstn: got %b, required 1", par_rstn); end
        n_tests++;
        if (underruns !== 16'd0 || smp_data !== 16'd0 || rd_addr !== 24'd0) begin
            n_fail++; $display("FAIL reset_values: got und=%h data=%h addr=%h, required zeros", underruns, smp_data, rd_addr);
        end
        @(negedge clk); rstn = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        setup(32'd800, 32'd8, 0);
        pulse(1'b1, 1'b0);
        wait_done(2000, "basic");
        n_tests++;
        if (tick_cnt != 4) begin n_fail++; $display("FAIL basic_ticks: got %0d, required 4", tick_cnt); end
        for (int i = 1; i < tick_t.size(); i++) begin
            n_tests++;
            if (tick_t[i] - tick_t[i-1] != 10) begin
                n_fail++; $display("FAIL basic_period: got %0d cycles, required 10", tick_t[i] - tick_t[i-1]);
            end
        end
        n_tests++;
        if (exp_q.size() != 0 || zero_cnt != 0 || underruns !== 16'd0) begin
            n_fail++; $display("FAIL basic_drain: got left=%0d zero=%0d und=%0d, required 0/0/0", exp_q.size(), zero_cnt, underruns);
        end
        idle(30);
        n_tests++;
        if (tick_cnt != 4 || done_cnt != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_after: got ticks=%0d done=%0d busy=%b, required 4/1/0", tick_cnt, done_cnt, busy);
        end
    endtask

    task automatic test_error();
        int k;
        setup(32'd800, 32'd8, 0);
        hdr0 = 16'h5249;
        pulse(1'b1, 1'b0);
        k = 0;
        while (err !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL error_flag: got err=%b busy=%b, required 1/0", err, busy); end
        @(posedge clk); #1;
        clr();
        idle(50);
        n_tests++;
        if (req_cnt != 0 || tick_cnt != 0 || err !== 1'b1) begin
            n_fail++; $display("FAIL error_quiet: got req=%0d ticks=%0d err=%b, required 0/0/1", req_cnt, tick_cnt, err);
        end
        hdr0 = 16'h4952;
        pulse(1'b1, 1'b0);
        idle(5);
        n_tests++;
        if (prst_cnt != 1 || err !== 1'b0) begin
            n_fail++; $display("FAIL error_restart: got prst_cycles=%0d err=%b, required 1/0", prst_cnt, err);
        end
        wait_done(2000, "error_rerun");
        n_tests++;
        if (tick_cnt != 4) begin n_fail++; $display("FAIL error_rerun_ticks: got %0d, required 4", tick_cnt); end
        idle(5);
    endtask

    task automatic test_underrun();
        setup(32'd4800, 32'd12, 40);
        pulse(1'b1, 1'b0);
        wait_done(6000, "underrun");
        n_tests++;
        if (zero_cnt == 0) begin n_fail++; $display("FAIL underrun_seen: got %0d empty ticks, required >0", zero_cnt); end
        n_tests++;
        if (underruns !== 16'(zero_cnt)) begin
            n_fail++; $display("FAIL underrun_count: got %0d, required %0d", underruns, zero_cnt);
        end
        n_tests++;
        if (tick_cnt - zero_cnt != 6 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL underrun_words: got %0d popped, %0d left, required 6/0", tick_cnt - zero_cnt, exp_q.size());
        end
        idle(5);
    endtask

    task automatic test_pacing();
        int n;
        setup(32'd4410, 32'h0001_0000, 0);
        pulse(1'b1, 1'b0);
        wait_tick(1000, "pacing");
        n = 0;
        for (int i = 0; i < SYS; i++) begin
            @(negedge clk);
            if (smp_tick) n++;
        end
        n_tests++;
        if (n != 4410) begin n_fail++; $display("FAIL pacing_count: got %0d ticks in %0d cycles, required 4410", n, SYS); end
        pulse(1'b0, 1'b1);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL pacing_stop: got busy=%b, required 0", busy); end
        idle(5);
    endtask

    task automatic test_stop();
        int k;
        setup(32'd800, 32'h0000_1000, 0);
        pulse(1'b1, 1'b0);
        wait_tick(1000, "stop");
        idle(20);
        @(posedge clk); #1;
        src_delay = 40;
        k = 0;
        do begin @(negedge clk); k++; end while (!rd_req && k < 200);
        n_tests++;
        if (!rd_req) begin n_fail++; $display("FAIL stop_req: no rd_req within 200 cycles"); end
        idle(3);
        pulse(1'b0, 1'b1);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle: got busy=%b, required 0", busy); end
        clr();
        idle(60);
        n_tests++;
        if (rv_cnt != 1 || pe_cnt != 0) begin
            n_fail++; $display("FAIL stop_late_valid: got rd_valid=%0d par_en=%0d, required 1/0", rv_cnt, pe_cnt);
        end
        n_tests++;
        if (done_cnt != 0 || tick_cnt != 0 || req_cnt != 0) begin
            n_fail++; $display("FAIL stop_quiet: got done=%0d ticks=%0d req=%0d, required 0/0/0", done_cnt, tick_cnt, req_cnt);
        end
    endtask

    task automatic test_start_stop();
        setup(32'd800, 32'd8, 0);
        pulse(1'b1, 1'b1);
        idle(20);
        n_tests++;
        if (req_cnt != 0 || prst_cnt != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL start_stop: got req=%0d prst=%0d busy=%b, required 0/0/0", req_cnt, prst_cnt, busy);
        end
    endtask

    task automatic test_async_reset();
        setup(32'd4800, 32'h0000_1000, 0);
        pulse(1'b1, 1'b0);
        wait_tick(1000, "areset");
        idle(10);
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({busy, rd_req, smp_tick, err, par_en} !== 5'b0 || par_rstn !== 1'b1 || underruns !== 16'd0 || smp_data !== 16'd0) begin
            n_fail++; $display("FAIL async_reset: got busy=%b req=%b tick=%b err=%b und=%h data=%h, required idle zeros",
                               busy, rd_req, smp_tick, err, underruns, smp_data);
        end
        @(negedge clk); rstn = 1'b1;
        idle(3);
    endtask

    initial begin
        clr();
        test_reset();
        test_basic();
        test_error();
        test_underrun();
        test_pacing();
        test_stop();
        test_start_stop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
